// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg: default geometry and word/address typedefs for dp_ram
package dp_ram_pkg;
   localparam int DP_RAM_DATA_W_DEF = 4;
   localparam int DP_RAM_ADDR_W_DEF = 4;
   typedef logic [DP_RAM_DATA_W_DEF-1:0] dp_ram_data_t;
   typedef logic [DP_RAM_ADDR_W_DEF-1:0] dp_ram_addr_t;
endpackage

// File: rtl/dp_ram_rd_port.sv
// dp_ram_rd_port: registered read data and valid flag; DP_RAM_BYPASS_EN adds write-first forwarding
module dp_ram_rd_port
   import dp_ram_pkg::*;
#(
   parameter int data_width = DP_RAM_DATA_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic [data_width-1:0] mem_data,
`ifdef DP_RAM_BYPASS_EN
   input  logic                  bypass,
   input  logic [data_width-1:0] wt_data,
`endif
   output logic [data_width-1:0] data_out,
   output logic                  rd_valid
);
   logic [data_width-1:0] rd_data;
`ifdef DP_RAM_BYPASS_EN
   always_comb rd_data = bypass ? wt_data : mem_data;
`else
   always_comb rd_data = mem_data;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) data_out <= rd_data;
      end
   end
endmodule

// File: rtl/dp_ram.sv
// dp_ram: single-clock simple dual-port RAM, 1-cycle registered read, read-first unless DP_RAM_BYPASS_EN
module dp_ram
   import dp_ram_pkg::*;
#(
   parameter int data_width = DP_RAM_DATA_W_DEF,
   parameter int addr_width = DP_RAM_ADDR_W_DEF
) (
   input  logic                  clk_dp_ram,
   input  logic                  rst_n_dp_ram,
   input  logic                  wt_en_dp_ram,
   input  logic [addr_width-1:0] wt_addr,
   input  logic [data_width-1:0] data_in_dp_ram,
   input  logic                  rd_en_dp_ram,
   input  logic [addr_width-1:0] rd_addr,
   output logic [data_width-1:0] data_out_dp_ram,
   output logic                  rd_valid_dp_ram
);
   logic [data_width-1:0] mem [2**addr_width];
   always_ff @(posedge clk_dp_ram or negedge rst_n_dp_ram) begin
      if (!rst_n_dp_ram) mem <= '{default: '0};
      else if (wt_en_dp_ram) mem[wt_addr] <= data_in_dp_ram;
   end
   dp_ram_rd_port #(.data_width(data_width)) u_rd_port (
      .clk      (clk_dp_ram),
      .rst_n    (rst_n_dp_ram),
      .rd_en    (rd_en_dp_ram),
      .mem_data (mem[rd_addr]),
`ifdef DP_RAM_BYPASS_EN
      .bypass   (wt_en_dp_ram && (wt_addr == rd_addr)),
      .wt_data  (data_in_dp_ram),
`endif
      .data_out (data_out_dp_ram),
      .rd_valid (rd_valid_dp_ram)
   );
endmodule

// File: tb/tb_dp_ram.sv
// tb_dp_ram: directed stimulus with a queue scoreboard checked by an independent read monitor
module tb_dp_ram;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wt_en = 1'b0;
   logic [3:0] wt_addr = '0;
   logic [3:0] data_in = '0;
   logic       rd_en = 1'b0;
   logic [3:0] rd_addr = '0;
   logic [3:0] data_out;
   logic       rd_valid;
   logic [3:0] exp_q [$];
   int n_checks = 0;
   int n_fail = 0;

   dp_ram dut (
      .clk_dp_ram      (clk),
      .rst_n_dp_ram    (rst_n),
      .wt_en_dp_ram    (wt_en),
      .wt_addr         (wt_addr),
      .data_in_dp_ram  (data_in),
      .rd_en_dp_ram    (rd_en),
      .rd_addr         (rd_addr),
      .data_out_dp_ram (data_out),
      .rd_valid_dp_ram (rd_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every valid read result is matched against the oldest queued expectation
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) chk("sb_unexpected_valid", 32'(data_out), 32'hdead);
         else chk("sb_read_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [3:0] a, input logic [3:0] d);
      wt_en = 1'b1; wt_addr = a; data_in = d; rd_en = 1'b0;
      tick();
   endtask

   task automatic rd(input logic [3:0] a, input logic [3:0] e);
      wt_en = 1'b0; rd_en = 1'b1; rd_addr = a;
      exp_q.push_back(e);
      tick();
      chk("rd_valid_after_read", 32'(rd_valid), 32'd1);
   endtask

   task automatic idle();
      wt_en = 1'b0; rd_en = 1'b0;
      tick();
   endtask

   initial begin
      logic [3:0] a;
      wt_en = 1'b1; wt_addr = 4'd0; data_in = 4'hF; rd_en = 1'b1; rd_addr = 4'd0;
      repeat (3) tick();
      chk("reset_data_out", 32'(data_out), 32'd0);
      chk("reset_rd_valid", 32'(rd_valid), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a = 4'(i);
         rd(a, 4'h0);
      end
      idle();
      wr(4'd6, 4'hF);
      rd(4'd6, 4'hF);
      idle();
      for (int i = 0; i < 16; i++) begin
         a = 4'(i);
         wr(a, ~a);
      end
      for (int i = 0; i < 16; i++) begin
         a = 4'(i);
         rd(a, ~a);
      end
      rd(4'd6, 4'h9);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("hold_data_out", 32'(data_out), 32'h9);
         chk("hold_rd_valid", 32'(rd_valid), 32'd0);
      end
      wr(4'd3, 4'h5);
      wt_en = 1'b1; wt_addr = 4'd3; data_in = 4'hA; rd_en = 1'b1; rd_addr = 4'd3;
`ifdef DP_RAM_BYPASS_EN
      exp_q.push_back(4'hA);
`else
      exp_q.push_back(4'h5);
`endif
      tick();
      rd(4'd3, 4'hA);
      idle();
      wr(4'd2, 4'h7);
      rd(4'd2, 4'h7);
      idle();
      wt_en = 1'b1; wt_addr = 4'd5; data_in = 4'h3; rd_en = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_data_out", 32'(data_out), 32'd0);
      chk("midreset_rd_valid", 32'(rd_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      rd(4'd2, 4'h0);
      rd(4'd5, 4'h0);
      rd(4'd6, 4'h0);
      idle();
      idle();
      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
